pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline stage register replacing the hand-written per-stage latch blocks (ID/IX, IX/MEM, MEM/WB).
- Carries a data payload plus a control bundle.
- Valid/ready handshake with a 2-entry skid buffer, so stalls propagate upstream without a combinational ready path.
- Synchronous flush inserts a bubble on branch/jump redirect.

---
 rtl/pipe_pkg.sv | 59 +++++
 rtl/pipe_stage_reg_slot.sv | 37 +++
 rtl/pipe_stage_reg.sv | 67 ++++++
 tb/tb_pipe_stage_reg.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, ID/IX control field layout and helpers for pipeline stage registers.
package pipe_pkg;
  localparam int PC_W = 32;
  localparam int IR_W = 32;
  localparam int REG_W = 32;
  localparam int ID_IX_DATA_W = PC_W + IR_W + 2 * REG_W;
  localparam int ID_IX_CTRL_W = 36;
  localparam int ALU_OP_LSB = 0;
  localparam int ALU_OP_W = 6;
  localparam int IS_BRANCH_BIT = 6;
  localparam int IS_JUMP_BIT = 7;
  localparam int OP2_SEL_BIT = 8;
  localparam int SHAMT_LSB = 9;
  localparam int SHAMT_W = 6;
  localparam int BRANCH_TYPE_LSB = 15;
  localparam int BRANCH_TYPE_W = 2;
  localparam int ACCESS_SIZE_LSB = 17;
  localparam int ACCESS_SIZE_W = 2;
  localparam int RW_BIT = 19;
  localparam int MEM_SEXT_BIT = 20;
  localparam int RES_DATA_SEL_BIT = 21;
  localparam int RT_LSB = 22;
  localparam int RT_W = 5;
  localparam int RD_LSB = 27;
  localparam int RD_W = 5;
  localparam int DEST_REG_SEL_BIT = 32;
  localparam int WRITE_TO_REG_BIT = 33;
  localparam int IS_JAL_BIT = 34;
  localparam int IS_JR_BIT = 35;
  // Field order matches the bit offsets above (MSB first).
  typedef struct packed {
    logic       is_jr;
    logic       is_jal;
    logic       write_to_reg;
    logic       dest_reg_sel;
    logic [4:0] rd;
    logic [4:0] rt;
    logic       res_data_sel;
    logic       memory_sign_extend;
    logic       rw;
    logic [1:0] access_size;
    logic [1:0] branch_type;
    logic [5:0] shift_amount;
    logic       op2_sel;
    logic       is_jump;
    logic       is_branch;
    logic [5:0] alu_op;
  } id_ix_ctrl_t;
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [IR_W-1:0]  ir;
    logic [REG_W-1:0] a;
    logic [REG_W-1:0] b;
  } id_ix_data_t;
  typedef enum logic {SRC_IN = 1'b0, SRC_SKID = 1'b1} main_src_e;
  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {main_v & skid_v, main_v ^ skid_v};
  endfunction
endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one valid + data + ctrl holding register; clear wins over load and leaves data intact.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = ID_IX_DATA_W,
  parameter int CTRL_W = ID_IX_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: falling-edge pipeline stage register with valid/ready handshake,
// 2-entry skid buffer (registered in_ready) and synchronous flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = ID_IX_DATA_W,
  parameter int CTRL_W = ID_IX_CTRL_W,
  parameter bit ZERO_CTRL_ON_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  logic              w_main_valid, w_skid_valid;
  logic              w_acc, w_pop;
  logic              w_main_load, w_main_clear, w_skid_load, w_skid_clear;
  logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_din;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_cin;
  main_src_e         w_src;
  assign in_ready = !w_skid_valid;
  assign w_acc = in_valid & in_ready;
  assign w_pop = w_main_valid & out_ready;
  // With the skid full, main refills only from skid so order is preserved.
  assign w_src        = w_skid_valid ? SRC_SKID : SRC_IN;
  assign w_main_load  = !flush & (w_skid_valid ? w_pop : (w_acc & (!w_main_valid | w_pop)));
  assign w_main_clear = flush | (w_main_valid & !w_skid_valid & !w_acc & w_pop);
  assign w_skid_load  = !flush & w_main_valid & !w_skid_valid & w_acc & !w_pop;
  assign w_skid_clear = flush | (w_skid_valid & w_pop);
  assign w_main_din   = (w_src == SRC_SKID) ? w_skid_data : in_data;
  assign w_main_cin   = (w_src == SRC_SKID) ? w_skid_ctrl : in_ctrl;
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_main_load),
    .i_clear(w_main_clear),
    .i_data (w_main_din),
    .i_ctrl (w_main_cin),
    .o_valid(w_main_valid),
    .o_data (w_main_data),
    .o_ctrl (w_main_ctrl)
  );
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_skid_load),
    .i_clear(w_skid_clear),
    .i_data (in_data),
    .i_ctrl (in_ctrl),
    .o_valid(w_skid_valid),
    .o_data (w_skid_data),
    .o_ctrl (w_skid_ctrl)
  );
  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  // Bubbles must never carry write_to_reg/rw downstream.
  assign out_ctrl  = (!ZERO_CTRL_ON_BUBBLE || w_main_valid) ? w_main_ctrl : '0;
  assign occupancy = occ_count(w_main_valid, w_skid_valid);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench; driver pushes accepted items, monitor pops and compares.
module tb_pipe_stage_reg;
  typedef struct {
    logic [127:0] d;
    logic [35:0]  c;
  } item_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic [35:0]  in_ctrl = '0;
  logic         in_ready, out_valid, in_ready0, out_valid0;
  logic [127:0] out_data, out_data0;
  logic [35:0]  out_ctrl, out_ctrl0;
  logic [1:0]   occupancy, occupancy0;
  item_t        q[$];
  int           checks = 0, errors = 0, pushed = 0, popped = 0, occ_pre = 0;
  int           nxt = 0;
  pipe_stage_reg #(.DATA_W(128), .CTRL_W(36), .ZERO_CTRL_ON_BUBBLE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy)
  );
  pipe_stage_reg #(.DATA_W(128), .CTRL_W(36), .ZERO_CTRL_ON_BUBBLE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occupancy0)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [127:0] mk(input logic [31:0] x);
    return {x, ~x, x ^ 32'hA5A5_A5A5, x};
  endfunction
  // Inputs change 1 after posedge; monitor samples 3 after; driver books acceptance 4 after.
  task automatic step(input logic v, input logic [31:0] x, input logic [35:0] c,
                      input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid = v; in_data = mk(x); in_ctrl = c; out_ready = r; flush = f;
    #3;
    if (f) q.delete();
    else if (v && occ_pre < 2) begin
      q.push_back('{mk(x), c});
      pushed++;
    end
  endtask
  task automatic after_edge();
    @(negedge clk);
    #1;
  endtask
  always begin
    @(posedge clk);
    #3;
    occ_pre = q.size();
    chk("occupancy", 128'(occupancy), 128'(occ_pre));
    chk("in_ready", 128'(in_ready), 128'(occ_pre < 2));
    chk("out_valid", 128'(out_valid), 128'(occ_pre != 0));
    if (occ_pre == 0) chk("bubble_ctrl", 128'(out_ctrl), 128'h0);
    else chk("out_ctrl", 128'(out_ctrl), 128'(q[0].c));
    if (!rst && !flush && out_valid && out_ready && q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      void'(q.pop_front());
      popped++;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0, v_r;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'h0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_out_ctrl", 128'(out_ctrl), 128'h0);
    chk("rst_in_ready", 128'(in_ready), 128'h1);
    chk("rst_occupancy", 128'(occupancy), 128'h0);
    rst = 1'b0;
    // streaming 1..5
    p0 = popped;
    for (int i = 1; i <= 5; i++) step(1'b1, 32'(i), {4'h3, 32'(i)}, 1'b1, 1'b0);
    step(1'b0, 32'h0, 36'h0, 1'b1, 1'b0);
    after_edge();
    chk("stream_pops", 128'(popped - p0), 128'd5);
    chk("stream_last", out_data, mk(32'h5));
    // stall and skid
    p0 = popped;
    step(1'b1, 32'hA, {4'h1, 32'hA}, 1'b0, 1'b0);
    step(1'b1, 32'hB, {4'h1, 32'hB}, 1'b0, 1'b0);
    after_edge();
    chk("skid_occupancy", 128'(occupancy), 128'd2);
    chk("skid_in_ready", 128'(in_ready), 128'h0);
    chk("skid_head", out_data, mk(32'hA));
    step(1'b1, 32'hC, {4'h1, 32'hC}, 1'b0, 1'b0);
    after_edge();
    chk("held_off_occ", 128'(occupancy), 128'd2);
    step(1'b1, 32'hC, {4'h1, 32'hC}, 1'b1, 1'b0);
    step(1'b1, 32'hC, {4'h1, 32'hC}, 1'b1, 1'b0);
    step(1'b0, 32'h0, 36'h0, 1'b1, 1'b0);
    after_edge();
    chk("skid_pops", 128'(popped - p0), 128'd3);
    chk("skid_drained", 128'(out_valid), 128'h0);
    // flush with simultaneous accept
    step(1'b1, 32'h10, {4'h2, 32'h10}, 1'b0, 1'b0);
    step(1'b1, 32'h11, {4'h2, 32'h11}, 1'b0, 1'b0);
    step(1'b1, 32'hD, {4'h2, 32'hD}, 1'b1, 1'b1);
    after_edge();
    chk("flush_out_valid", 128'(out_valid), 128'h0);
    chk("flush_occupancy", 128'(occupancy), 128'd0);
    chk("flush_in_ready", 128'(in_ready), 128'h1);
    step(1'b0, 32'h0, 36'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 36'h0, 1'b1, 1'b0);
    // bubble gating
    step(1'b1, 32'h77, 36'hF_FFFF_FFFF, 1'b0, 1'b0);
    after_edge();
    chk("gate_valid_ctrl", 128'(out_ctrl), 128'(36'hF_FFFF_FFFF));
    chk("nogate_valid_ctrl", 128'(out_ctrl0), 128'(36'hF_FFFF_FFFF));
    step(1'b0, 32'h0, 36'h0, 1'b1, 1'b0);
    after_edge();
    chk("gate_bubble_valid", 128'(out_valid), 128'h0);
    chk("gate_bubble_ctrl", 128'(out_ctrl), 128'h0);
    chk("nogate_bubble_ctrl", 128'(out_ctrl0), 128'(36'hF_FFFF_FFFF));
    // async reset while full
    step(1'b1, 32'h20, {4'h4, 32'h20}, 1'b0, 1'b0);
    step(1'b1, 32'h21, {4'h4, 32'h21}, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_occ", 128'(occupancy), 128'd2);
    rst = 1'b1; in_valid = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'h0);
    chk("midrst_out_ctrl", 128'(out_ctrl), 128'h0);
    chk("midrst_in_ready", 128'(in_ready), 128'h1);
    chk("midrst_occupancy", 128'(occupancy), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // random back-pressure, 1000 items
    p0 = popped;
    v_r = pushed;
    nxt = 0;
    for (int i = 0; i < 8000 && pushed - v_r < 1000; i++) begin
      nxt = 32'h1000 + pushed - v_r;
      step(($urandom % 4) != 0, 32'(nxt), {4'h9, 32'(nxt)}, ($urandom % 2) == 1, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 36'h0, 1'b1, 1'b0);
    chk("rand_pushed", 128'(pushed - v_r), 128'd1000);
    chk("rand_popped", 128'(popped - p0), 128'd1000);
    chk("rand_empty", 128'(q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
